sensor_conditioner: RTL and testbench
=====================================

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive identical synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, is the debounce counter width; it SHALL be at least clog2(DEBOUNCE_CYCLES).
REQ-003 clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 raw_car_ns  input  1  asynchronous north-south car sensor.
REQ-006 raw_car_ew  input  1  asynchronous east-west car sensor.
REQ-007 raw_ped  input  1  asynchronous pedestrian push-button.
REQ-008 light_ped  input  2  pedestrian-light code fed back from the traffic light controller; 2'b11 = both walk lights on.
REQ-009 car_ns  output  1  debounced north-south car presence, to the controller's car_ns.
REQ-010 car_ew  output  1  debounced east-west car presence, to the controller's car_ew.
REQ-011 ped  output  1  latched pedestrian request, to the controller's ped.
REQ-012 ped_served  output  1  one-cycle pulse when a latched request is cleared.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL run a 4-state debounce FSM: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-015 STABLE_LO with synced sample 1 -> CHK_HI, count=1; STABLE_HI with sample 0 -> CHK_LO, count=1.
REQ-016 CHK_HI: sample 0 -> STABLE_LO; sample 1 and count==DEBOUNCE_CYCLES-1 -> STABLE_HI; otherwise count+1.
REQ-017 CHK_LO mirrors CHK_HI with polarities swapped.
REQ-018 Debounced level SHALL be 1 in STABLE_HI and CHK_LO, and 0 in STABLE_LO and CHK_HI (registered, glitch-free).
REQ-019 A clean raw edge SHALL change the debounced level on the (DEBOUNCE_CYCLES+2)th rising clk edge after the raw change; any pulse shorter than DEBOUNCE_CYCLES synced cycles SHALL be rejected entirely.
REQ-020 car_ns and car_ew SHALL equal the respective debounced levels.
REQ-021 ped SHALL set on the cycle after a 0->1 transition of the debounced ped level and hold until cleared.
REQ-022 ped SHALL clear on the clock after light_ped==2'b11 is sampled while ped==1; ped_served pulses high on that same edge for exactly one cycle.
REQ-023 When a set and a clear occur in the same cycle, clear SHALL win: a press during the walk phase counts as served.
REQ-024 Holding the button SHALL NOT re-set ped after a clear; a new debounced 0->1 edge is required.
REQ-025 Debounce counters SHALL never wrap; they stop at DEBOUNCE_CYCLES-1 by construction of REQ-016.

Reset
REQ-026 On rst low, asynchronously: synchronizer flops 0, all FSMs STABLE_LO, counters 0, car_ns=0, car_ew=0, ped=0, ped_served=0.
REQ-027 Reset asserted mid-debounce or with ped latched SHALL discard all pending state; after release, a held input needs a full DEBOUNCE_CYCLES+2 edges to be reported.

Structure
REQ-028 A shared package/header SHALL hold the debounce state encodings and the PED_* light codes (PED_BOTH=2'b11), shared with the traffic light controller.
REQ-029 A sub-module debouncer (synchronizer + FSM + counter, parameterised by DEBOUNCE_CYCLES) SHALL be instantiated three times; the pedestrian latch lives in the top module.

Verification
REQ-030 DEBOUNCE_CYCLES=4, raw_car_ns 0->1 held -> car_ns rises on the 6th rising edge; 1->0 held -> falls 6 edges later.
REQ-031 raw_car_ew high for 3 clocks, then low -> car_ew stays 0 throughout; the FSM returns to STABLE_LO.
REQ-032 raw_ped pulse of 10 clocks, light_ped=2'b00 -> ped=1 and stays 1 after release; then light_ped=2'b11 for 1 cycle -> ped=0 and ped_served=1 for exactly one cycle.
REQ-033 Debounced ped rising edge coincident with light_ped=2'b11 -> ped remains 0 and ped_served stays 0.
REQ-034 rst pulsed low while CHK_HI count=2 and ped=1 -> all outputs 0 immediately; the held input reappears only after 6 edges post-release.
REQ-035 Button held through a clear -> ped stays 0 until the button is released (debounced) and pressed again.

Source files
------------

// File: rtl/sensor_conditioner_pkg.sv
// rtl/sensor_conditioner_pkg.sv - debounce state encodings and pedestrian light codes
// Shared with the traffic light controller so both sides agree on the PED_* codes.
package sensor_conditioner_pkg;

    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'b00,
        DB_CHK_HI    = 2'b01,
        DB_STABLE_HI = 2'b10,
        DB_CHK_LO    = 2'b11
    } db_state_e;

    localparam logic [1:0] PED_NONE = 2'b00;
    localparam logic [1:0] PED_NS   = 2'b01;
    localparam logic [1:0] PED_EW   = 2'b10;
    localparam logic [1:0] PED_BOTH = 2'b11;

endpackage

// File: rtl/sensor_conditioner_if.sv
// rtl/sensor_conditioner_if.sv - raw sensor inputs and conditioned outputs of the sensor conditioner
// master drives the raw sensors and the light feedback; slave is the conditioner itself.
interface sensor_conditioner_if;

    logic       raw_car_ns;
    logic       raw_car_ew;
    logic       raw_ped;
    logic [1:0] light_ped;
    logic       car_ns;
    logic       car_ew;
    logic       ped;
    logic       ped_served;

    modport master (
        output raw_car_ns,
        output raw_car_ew,
        output raw_ped,
        output light_ped,
        input  car_ns,
        input  car_ew,
        input  ped,
        input  ped_served
    );

    modport slave (
        input  raw_car_ns,
        input  raw_car_ew,
        input  raw_ped,
        input  light_ped,
        output car_ns,
        output car_ew,
        output ped,
        output ped_served
    );

endinterface

// File: rtl/sensor_conditioner_debounce.sv
// rtl/sensor_conditioner_debounce.sv - two-flop synchronizer plus four-state debounce FSM
// The level only moves after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
module sensor_conditioner_debounce
    import sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;

    // Counter saturates at CNT_LAST because that value always forces a state exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            case (state_q)
                DB_STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= DB_CHK_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                DB_CHK_HI: begin
                    if (!sync2_q) begin
                        state_q <= DB_STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_STABLE_HI;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DB_STABLE_HI: begin
                    if (!sync2_q) begin
                        state_q <= DB_CHK_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                DB_CHK_LO: begin
                    if (sync2_q) begin
                        state_q <= DB_STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_STABLE_LO;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= DB_STABLE_LO;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - debounces car and pedestrian sensors and latches pedestrian requests
// Three debouncer instances feed the controller; the pedestrian latch is cleared by walk feedback.
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_conditioner_if.slave  bus
);

    logic deb_ns;
    logic deb_ew;
    logic deb_ped;
    logic deb_ped_prev_q;
    logic ped_q;
    logic ped_d;
    logic ped_served_q;
    logic ped_served_d;
    logic ped_rise;

    sensor_conditioner_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_ns (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus.raw_car_ns),
        .level_o (deb_ns)
    );

    sensor_conditioner_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_ew (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus.raw_car_ew),
        .level_o (deb_ew)
    );

    sensor_conditioner_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb_ped (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (bus.raw_ped),
        .level_o (deb_ped)
    );

    assign ped_rise = deb_ped & ~deb_ped_prev_q;

    // Walk feedback beats a new press, so a press during the walk phase is already served.
    always_comb begin
        ped_d        = ped_q;
        ped_served_d = 1'b0;
        if (bus.light_ped == PED_BOTH) begin
            ped_d        = 1'b0;
            ped_served_d = ped_q;
        end else if (ped_rise) begin
            ped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_ped_prev_q <= 1'b0;
            ped_q          <= 1'b0;
            ped_served_q   <= 1'b0;
        end else begin
            deb_ped_prev_q <= deb_ped;
            ped_q          <= ped_d;
            ped_served_q   <= ped_served_d;
        end
    end

    assign bus.car_ns     = deb_ns;
    assign bus.car_ew     = deb_ew;
    assign bus.ped        = ped_q;
    assign bus.ped_served = ped_served_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - table, corner-case and randomized checks of sensor_conditioner
module tb_sensor_conditioner;
    import sensor_conditioner_pkg::*;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: history of raw values per channel, newest at index 0.
    bit hist [3][0:DC+1];
    bit m_lvl [3];
    bit m_prev;
    bit m_ped;
    bit m_srv;

    typedef struct {
        string      name;
        logic       ns;
        logic       ew;
        logic       pd;
        logic [1:0] light;
        int         cycles;
        logic       e_ns;
        logic       e_ew;
        logic       e_ped;
        logic       e_srv;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (hist[c, i]) hist[c][i] = 1'b0;
        foreach (m_lvl[c]) m_lvl[c] = 1'b0;
        m_prev = 1'b0;
        m_ped  = 1'b0;
        m_srv  = 1'b0;
    endfunction

    // A level flips once the DC samples that have crossed the synchronizer all disagree with it.
    function automatic void model_step();
        bit raw [3];
        bit rise;
        bit all_diff;
        raw[0] = bus.raw_car_ns;
        raw[1] = bus.raw_car_ew;
        raw[2] = bus.raw_ped;
        rise   = m_lvl[2] & ~m_prev;
        m_srv  = 1'b0;
        if (bus.light_ped == PED_BOTH) begin
            m_srv = m_ped;
            m_ped = 1'b0;
        end else if (rise) begin
            m_ped = 1'b1;
        end
        m_prev = m_lvl[2];
        for (int c = 0; c < 3; c++) begin
            for (int i = DC + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = raw[c];
            all_diff = 1'b1;
            for (int i = 2; i <= DC + 1; i++)
                if (hist[c][i] == m_lvl[c]) all_diff = 1'b0;
            if (all_diff) m_lvl[c] = ~m_lvl[c];
        end
    endfunction

    task automatic check_model();
        chk("model_car_ns", bus.car_ns, m_lvl[0]);
        chk("model_car_ew", bus.car_ew, m_lvl[1]);
        chk("model_ped", bus.ped, m_ped);
        chk("model_ped_served", bus.ped_served, m_srv);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        #1;
        check_model();
    endtask

    task automatic drive(input logic ns, input logic ew, input logic pd, input logic [1:0] light);
        bus.raw_car_ns = ns;
        bus.raw_car_ew = ew;
        bus.raw_ped    = pd;
        bus.light_ped  = light;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_car_ns"}, bus.car_ns, 1'b0);
        chk({tag, "_car_ew"}, bus.car_ew, 1'b0);
        chk({tag, "_ped"}, bus.ped, 1'b0);
        chk({tag, "_ped_served"}, bus.ped_served, 1'b0);
    endtask

    initial begin
        vecs[0] = '{"idle",          0, 0, 0, 2'b00,  3, 0, 0, 0, 0};
        vecs[1] = '{"ns_rise_e5",    1, 0, 0, 2'b00,  5, 0, 0, 0, 0};
        vecs[2] = '{"ns_rise_e6",    1, 0, 0, 2'b00,  1, 1, 0, 0, 0};
        vecs[3] = '{"ns_fall_e5",    0, 0, 0, 2'b00,  5, 1, 0, 0, 0};
        vecs[4] = '{"ns_fall_e6",    0, 0, 0, 2'b00,  1, 0, 0, 0, 0};
        vecs[5] = '{"ew_glitch3",    0, 1, 0, 2'b00,  3, 0, 0, 0, 0};
        vecs[6] = '{"ew_after",      0, 0, 0, 2'b00,  8, 0, 0, 0, 0};
        vecs[7] = '{"ped_press10",   0, 0, 1, 2'b00, 10, 0, 0, 1, 0};
        vecs[8] = '{"ped_held_rel",  0, 0, 0, 2'b00,  8, 0, 0, 1, 0};
        vecs[9] = '{"ped_clear",     0, 0, 0, 2'b11,  1, 0, 0, 0, 1};

        drive(0, 0, 0, PED_NONE);
        model_reset();
        #2;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b1;

        foreach (vecs[v]) begin
            drive(vecs[v].ns, vecs[v].ew, vecs[v].pd, vecs[v].light);
            repeat (vecs[v].cycles) step();
            chk({vecs[v].name, "_car_ns"}, bus.car_ns, vecs[v].e_ns);
            chk({vecs[v].name, "_car_ew"}, bus.car_ew, vecs[v].e_ew);
            chk({vecs[v].name, "_ped"}, bus.ped, vecs[v].e_ped);
            chk({vecs[v].name, "_ped_served"}, bus.ped_served, vecs[v].e_srv);
        end
        drive(0, 0, 0, PED_NONE);
        step();
        chk("served_one_cycle", bus.ped_served, 1'b0);

        // Debounced press lands on the same edge as walk feedback.
        drive(0, 0, 1, PED_NONE);
        repeat (6) step();
        chk("coinc_pre_ped", bus.ped, 1'b0);
        drive(0, 0, 1, PED_BOTH);
        step();
        chk("coinc_ped", bus.ped, 1'b0);
        chk("coinc_served", bus.ped_served, 1'b0);
        drive(0, 0, 1, PED_NONE);
        step();
        chk("coinc_after_ped", bus.ped, 1'b0);

        // Button held through a clear needs a fresh debounced press.
        repeat (20) step();
        chk("held_ped", bus.ped, 1'b0);
        drive(0, 0, 0, PED_NONE);
        repeat (10) step();
        chk("released_ped", bus.ped, 1'b0);
        drive(0, 0, 1, PED_NONE);
        repeat (6) step();
        chk("press2_e6_ped", bus.ped, 1'b0);
        step();
        chk("press2_e7_ped", bus.ped, 1'b1);

        // Reset while ns sits in CHK_HI with count 2 and ped latched.
        drive(1, 0, 1, PED_NONE);
        repeat (4) step();
        chk("pre_rst_ped", bus.ped, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        step();
        step();
        rst = 1'b1;
        repeat (5) step();
        chk("post_rst_e5_car_ns", bus.car_ns, 1'b0);
        step();
        chk("post_rst_e6_car_ns", bus.car_ns, 1'b1);
        step();
        chk("post_rst_e7_ped", bus.ped, 1'b1);

        drive(0, 0, 0, PED_NONE);
        for (int n = 0; n < 3000; n++) begin
            bus.raw_car_ns = bus.raw_car_ns ^ ($urandom_range(0, 7) == 0);
            bus.raw_car_ew = bus.raw_car_ew ^ ($urandom_range(0, 7) == 0);
            bus.raw_ped    = bus.raw_ped ^ ($urandom_range(0, 7) == 0);
            bus.light_ped  = ($urandom_range(0, 15) == 0) ? PED_BOTH : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                model_reset();
                check_all_zero("rand_rst");
                step();
                rst = 1'b1;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
